// File: rtl/bus_uart_fifo.sv
// Buffered UART slave on the picorv32 native bus: TX/RX FIFOs, DATA/STAT/DIV registers.
// Define UART_IRQ_EN to add the IRQEN register at index 3 and drive irq; otherwise irq is 0.
module bus_uart_fifo #(
    parameter int unsigned DIV_RESET = 208,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic        clk_24,
    input  logic        resetn,
    input  logic        sel,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    // state   | meaning
    // S_IDLE  | line idle: TX waits for a queued byte, RX waits for a falling edge
    // S_START | start bit
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam logic [15:0] DIV_RST = 16'(DIV_RESET);

    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       div_q, div_d, div_new;
    logic              ovr_q, ovr_d, ferr_q, ferr_d;
    logic              ovr_set, ovr_clr, ferr_set, ferr_clr;
    logic [FIFO_AW:0]  txw_q, txw_d, txr_q, txr_d, rxw_q, rxw_d, rxr_q, rxr_d;
    logic [7:0]        tx_mem [DEPTH];
    logic [7:0]        rx_mem [DEPTH];
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              tx_full, tx_nempty, rx_full, rx_nempty, tx_idle;

    uart_st_e          txs_q, txs_d, rxs_q, rxs_d;
    logic [15:0]       tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [15:0]       rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]        tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]        tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic              tx_q, tx_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;

    logic              unused_bits;
    assign unused_bits = ^{wdata[31:16], wstrb[3:2]};

`ifdef UART_IRQ_EN
    logic [1:0]        irqen_q, irqen_d;
    logic              irq_q, irq_d;
`endif

    assign tx_full   = (txw_q[FIFO_AW] != txr_q[FIFO_AW]) &&
                       (txw_q[FIFO_AW-1:0] == txr_q[FIFO_AW-1:0]);
    assign rx_full   = (rxw_q[FIFO_AW] != rxr_q[FIFO_AW]) &&
                       (rxw_q[FIFO_AW-1:0] == rxr_q[FIFO_AW-1:0]);
    assign tx_nempty = (txw_q != txr_q);
    assign rx_nempty = (rxw_q != rxr_q);
    assign tx_idle   = ~tx_nempty && (txs_q == S_IDLE);

    always_comb begin
        ready_d  = sel & ~ready_q;
        rdata_d  = '0;
        div_d    = div_q;
        div_new  = div_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        ovr_clr  = 1'b0;
        ferr_clr = 1'b0;
`ifdef UART_IRQ_EN
        irqen_d  = irqen_q;
        irq_d    = |(irqen_q & {tx_idle, rx_nempty});
`endif
        // Side effects fire only on the cycle the acknowledge is raised.
        if (ready_d && wstrb != 4'b0) begin
            case (addr)
                2'd0: tx_push = wstrb[0] & ~tx_full;
                2'd1: begin
                    ovr_clr  = wstrb[0] & wdata[3];
                    ferr_clr = wstrb[0] & wdata[4];
                end
                2'd2: begin
                    if (wstrb[0]) div_new[7:0]  = wdata[7:0];
                    if (wstrb[1]) div_new[15:8] = wdata[15:8];
                    div_d = (div_new < 16'd2) ? 16'd2 : div_new;
                end
                default: begin
`ifdef UART_IRQ_EN
                    if (wstrb[0]) irqen_d = wdata[1:0];
`endif
                end
            endcase
        end else if (ready_d) begin
            case (addr)
                2'd0: if (rx_nempty) begin
                    rdata_d = {24'b0, rx_mem[rxr_q[FIFO_AW-1:0]]};
                    rx_pop  = 1'b1;
                end
                2'd1: rdata_d = {27'b0, ferr_q, ovr_q, tx_idle, tx_full, rx_nempty};
                2'd2: rdata_d = {16'b0, div_q};
                default: begin
`ifdef UART_IRQ_EN
                    rdata_d = {30'b0, irqen_q};
`endif
                end
            endcase
        end

        txs_d    = txs_q;
        tx_cnt_d = tx_cnt_q;
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_d     = tx_q;
        tx_pop   = 1'b0;
        case (txs_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_nempty) begin
                    tx_pop   = 1'b1;
                    tx_sh_d  = tx_mem[txr_q[FIFO_AW-1:0]];
                    tx_div_d = div_q;
                    tx_cnt_d = div_q - 16'd1;
                    tx_d     = 1'b0;
                    txs_d    = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_d     = tx_sh_q[0];
                    tx_bit_d = 3'd0;
                    tx_cnt_d = tx_div_q - 16'd1;
                    txs_d    = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d  = 1'b1;
                        txs_d = S_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_d     = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == 16'd0) begin
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (tx_nempty) begin
                        tx_pop   = 1'b1;
                        tx_sh_d  = tx_mem[txr_q[FIFO_AW-1:0]];
                        tx_div_d = div_q;
                        tx_cnt_d = div_q - 16'd1;
                        tx_d     = 1'b0;
                        txs_d    = S_START;
                    end else begin
                        txs_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
        endcase

        rxs_d    = rxs_q;
        rx_cnt_d = rx_cnt_q;
        rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        case (rxs_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_div_d = div_q;
                    rx_cnt_d = (div_q >> 1) - 16'd1;
                    rxs_d    = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_cnt_d = rx_div_q - 16'd1;
                    rx_bit_d = 3'd0;
                    rxs_d    = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = rx_div_q - 16'd1;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rxs_d = S_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == 16'd0) begin
                    rxs_d = S_IDLE;
                    if (!rx_s2_q)     ferr_set = 1'b1;
                    else if (rx_full) ovr_set  = 1'b1;
                    else              rx_push  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
        endcase

        txw_d  = txw_q + {{FIFO_AW{1'b0}}, tx_push};
        txr_d  = txr_q + {{FIFO_AW{1'b0}}, tx_pop};
        rxw_d  = rxw_q + {{FIFO_AW{1'b0}}, rx_push};
        rxr_d  = rxr_q + {{FIFO_AW{1'b0}}, rx_pop};
        ovr_d  = (ovr_q & ~ovr_clr) | ovr_set;
        ferr_d = (ferr_q & ~ferr_clr) | ferr_set;
    end

    always_ff @(posedge clk_24) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            div_q     <= DIV_RST;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            txw_q     <= '0;
            txr_q     <= '0;
            rxw_q     <= '0;
            rxr_q     <= '0;
            txs_q     <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_div_q  <= DIV_RST;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_q      <= 1'b1;
            rxs_q     <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_div_q  <= DIV_RST;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            div_q     <= div_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            txw_q     <= txw_d;
            txr_q     <= txr_d;
            rxw_q     <= rxw_d;
            rxr_q     <= rxr_d;
            txs_q     <= txs_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_div_q  <= tx_div_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_q      <= tx_d;
            rxs_q     <= rxs_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_div_q  <= rx_div_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk_24) begin
        if (tx_push) tx_mem[txw_q[FIFO_AW-1:0]] <= wdata[7:0];
        if (rx_push) rx_mem[rxw_q[FIFO_AW-1:0]] <= rx_sh_q;
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clk_24) begin
        if (!resetn) begin
            irqen_q <= 2'b00;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign tx    = tx_q;
endmodule
